// File: rtl/sha2_msg_pack.sv
// Write side of the HMAC message FIFO: packs byte-strobed writes into {data, mask} words
// (first byte in data[31:24]), counts message bits, flushes the trailing partial word.
// Optional macro SHA2_PACK_STRB_CHECK_EN rejects non-contiguous strobes and pulses err_o.
module sha2_msg_pack #(
  parameter bit BigEndianIn = 1'b0,
  parameter int LenWidth    = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sha_en,
  input  logic                hash_start,
  input  logic                hash_process,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [31:0]         wr_data_i,
  input  logic [3:0]          wr_strb_i,
  output logic                fifo_wvalid_o,
  input  logic                fifo_wready_i,
  output logic [35:0]         fifo_wdata_o,
  output logic [LenWidth-1:0] message_length_o,
  output logic                flush_done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {StIdle, StActive, StFlush, StDone} st_e;

  st_e                 st_q, st_d;
  logic [31:0]         out_data_q, out_data_d;
  logic [3:0]          out_mask_q, out_mask_d;
  logic                out_vld_q, out_vld_d;
  logic [23:0]         hold_q, hold_d;
  logic [1:0]          hold_cnt_q, hold_cnt_d;
  logic [LenWidth-1:0] len_q, len_d;

  logic        slot_free;
  logic        accept;
  logic        strb_bad;
  logic [31:0] new_bytes;
  logic [2:0]  new_cnt;
  logic [2:0]  total;
  logic [55:0] cat;
  logic [3:0]  part_mask;

  function automatic int lane_of(input int k);
    return BigEndianIn ? 3 - k : k;
  endfunction

  // The output slot can take a new word if it is empty or being drained this cycle.
  assign slot_free = !out_vld_q || fifo_wready_i;
  assign accept    = wr_valid_i && wr_ready_o;

`ifdef SHA2_PACK_STRB_CHECK_EN
  logic err_q;

  assign strb_bad = !(wr_strb_i inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                                        4'h6, 4'hC, 4'h7, 4'hE, 4'hF});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && strb_bad;
    end
  end

  assign err_o = err_q;
`else
  assign strb_bad = 1'b0;
  assign err_o    = 1'b0;
`endif

  // Compact the strobed bytes, earliest first, into the top of new_bytes.
  always_comb begin
    new_bytes = '0;
    new_cnt   = '0;
    for (int k = 0; k < 4; k++) begin
      if (wr_strb_i[lane_of(k)]) begin
        new_bytes[31 - 8*new_cnt -: 8] = wr_data_i[8*lane_of(k) +: 8];
        new_cnt = new_cnt + 3'd1;
      end
    end
  end

  // Held bytes followed by new bytes, earliest at cat[55:48], zero filled.
  assign cat   = {hold_q, 32'h0} | ({new_bytes, 24'h0} >> (8 * hold_cnt_q));
  assign total = {1'b0, hold_cnt_q} + new_cnt;

  always_comb begin
    case (hold_cnt_q)
      2'd1:    part_mask = 4'b1000;
      2'd2:    part_mask = 4'b1100;
      2'd3:    part_mask = 4'b1110;
      default: part_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (!sha_en) begin
      st_d = StIdle;
    end else if (hash_start) begin
      st_d = StActive;
    end else begin
      case (st_q)
        StActive: if (hash_process) st_d = StFlush;
        StFlush:  if (hold_cnt_q == 2'd0 || slot_free) st_d = StDone;
        default:  ;
      endcase
    end
  end

  always_comb begin
    wr_ready_o   = 1'b0;
    flush_done_o = 1'b0;
    case (st_q)
      StActive: wr_ready_o   = slot_free;
      StDone:   flush_done_o = !out_vld_q;
      default:  ;
    endcase
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    len_d      = len_q;

    if (out_vld_q && fifo_wready_i) begin
      out_vld_d  = 1'b0;
      out_data_d = '0;
      out_mask_d = '0;
    end

    if (!sha_en) begin
      out_vld_d  = 1'b0;
      out_data_d = '0;
      out_mask_d = '0;
      hold_d     = '0;
      hold_cnt_d = '0;
    end else if (hash_start) begin
      out_vld_d  = 1'b0;
      out_data_d = '0;
      out_mask_d = '0;
      hold_d     = '0;
      hold_cnt_d = '0;
      len_d      = '0;
    end else if (accept) begin
      if (!strb_bad) begin
        len_d = len_q + LenWidth'({new_cnt, 3'b000});
        if (total >= 3'd4) begin
          out_vld_d  = 1'b1;
          out_data_d = cat[55:24];
          out_mask_d = 4'hF;
          hold_d     = cat[23:0];
          hold_cnt_d = 2'(total - 3'd4);
        end else begin
          hold_d     = cat[55:32];
          hold_cnt_d = total[1:0];
        end
      end
    end else if (st_q == StFlush && hold_cnt_q != 2'd0 && slot_free) begin
      out_vld_d  = 1'b1;
      out_data_d = {hold_q, 8'h00};
      out_mask_d = part_mask;
      hold_d     = '0;
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_mask_q <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      len_q      <= len_d;
    end
  end

  assign fifo_wvalid_o    = out_vld_q;
  assign fifo_wdata_o     = {out_data_q, out_mask_q};
  assign message_length_o = len_q;

endmodule
